// File: rtl/ones_pkg.sv
// Shared definitions for the ones-count post-processing blocks behind the
// 32-bit popcount stage.
package ones_pkg;

    localparam int ONES_CNT_W   = 6;
    localparam int ONES_CNT_MAX = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } ones_state_e;

    function automatic int sum_width(input int len, input int max_val);
        return $clog2(len * max_val + 1);
    endfunction

endpackage

// File: rtl/ones_minmax.sv
// Running min/max tracker. Clear and sample may coincide: the sample then
// seeds the fresh run, which is how back-to-back windows avoid a dead cycle.
module ones_minmax
    import ones_pkg::*;
#(
    parameter int CNT_W = ONES_CNT_W
) (
    input  logic             sys_clk,
    input  logic             in_rst_n,
    input  logic [CNT_W-1:0] smp,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    output logic [CNT_W-1:0] out_max,
    output logic [CNT_W-1:0] out_min
);

    logic [CNT_W-1:0] run_max_q, run_max_d;
    logic [CNT_W-1:0] run_min_q, run_min_d;
    logic [CNT_W-1:0] out_max_q, out_max_d;
    logic [CNT_W-1:0] out_min_q, out_min_d;
    logic [CNT_W-1:0] base_max;
    logic [CNT_W-1:0] base_min;

    always_comb begin
        base_max  = clr ? '0 : run_max_q;
        base_min  = clr ? '1 : run_min_q;
        run_max_d = base_max;
        run_min_d = base_min;
        out_max_d = out_max_q;
        out_min_d = out_min_q;
        if (en) begin
            if (smp > base_max) run_max_d = smp;
            if (smp < base_min) run_min_d = smp;
        end
        // Output capture uses the completed run, never the coinciding sample.
        if (ld) begin
            out_max_d = run_max_q;
            out_min_d = run_min_q;
        end
    end

    always_ff @(posedge sys_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            run_max_q <= '0;
            run_min_q <= '1;
            out_max_q <= '0;
            out_min_q <= '0;
        end else begin
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            out_max_q <= out_max_d;
            out_min_q <= out_min_d;
        end
    end

    assign out_max = out_max_q;
    assign out_min = out_min_q;

endmodule

// File: rtl/ones_window_acc.sv
// Windowed accumulator of per-word ones counts: reports window total,
// min/max and density alarms once every WIN_LEN accepted samples.
module ones_window_acc
    import ones_pkg::*;
#(
    parameter int CNT_W   = ONES_CNT_W,
    parameter int CNT_MAX = ONES_CNT_MAX,
    parameter int WIN_LEN = 16,
    parameter int THR_HI  = 400,
    parameter int THR_LO  = 64,
    localparam int SUM_W  = sum_width(WIN_LEN, CNT_MAX)
) (
    input  logic             sys_clk,
    input  logic             in_rst_n,
    input  logic             in_vld,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic             in_clr,
    output logic             out_vld,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_max,
    output logic [CNT_W-1:0] out_min,
    output logic             out_alarm_hi,
    output logic             out_alarm_lo,
    output logic             out_err
);

    localparam int SC_W = $clog2(WIN_LEN + 1);
    localparam logic [SC_W-1:0]  WIN_LEN_V = SC_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        return (c > CNT_MAX_V) ? CNT_MAX_V : c;
    endfunction

    function automatic logic above_hi(input logic [SUM_W-1:0] s);
        return {{(32-SUM_W){1'b0}}, s} > $unsigned(THR_HI);
    endfunction

    function automatic logic below_lo(input logic [SUM_W-1:0] s);
        return {{(32-SUM_W){1'b0}}, s} < $unsigned(THR_LO);
    endfunction

    ones_state_e      state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SC_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             hi_q, hi_d;
    logic             lo_q, lo_d;

    logic             accept;
    logic             close;
    logic [CNT_W-1:0] smp_sat;

    assign accept  = in_vld & ~in_clr;
    assign smp_sat = sat_cnt(in_cnt);
    assign close   = (state_q == ST_ACC) && (smp_cnt_q == WIN_LEN_V);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
        err_d     = err_q;
        vld_d     = 1'b0;
        sum_d     = sum_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (in_clr) begin
            state_d   = ST_IDLE;
            acc_d     = '0;
            smp_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            if (accept && (in_cnt > CNT_MAX_V)) err_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d   = ST_ACC;
                        acc_d     = SUM_W'(smp_sat);
                        smp_cnt_d = SC_W'(1);
                    end
                end
                ST_ACC: begin
                    if (close) begin
                        vld_d = 1'b1;
                        sum_d = acc_q;
                        hi_d  = above_hi(acc_q);
                        lo_d  = below_lo(acc_q);
                        // A sample in the closing cycle opens the next window.
                        if (accept) begin
                            acc_d     = SUM_W'(smp_sat);
                            smp_cnt_d = SC_W'(1);
                        end else begin
                            state_d   = ST_IDLE;
                            acc_d     = '0;
                            smp_cnt_d = '0;
                        end
                    end else if (accept) begin
                        acc_d     = acc_q + SUM_W'(smp_sat);
                        smp_cnt_d = smp_cnt_q + SC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            smp_cnt_q <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            sum_q     <= '0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            sum_q     <= sum_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    ones_minmax #(
        .CNT_W(CNT_W)
    ) u_minmax (
        .sys_clk (sys_clk),
        .in_rst_n(in_rst_n),
        .smp     (smp_sat),
        .en      (accept),
        .clr     (in_clr | close),
        .ld      (close & ~in_clr),
        .out_max (out_max),
        .out_min (out_min)
    );

    assign out_vld      = vld_q;
    assign out_sum      = sum_q;
    assign out_alarm_hi = hi_q;
    assign out_alarm_lo = lo_q;
    assign out_err      = err_q;

endmodule

// File: tb/tb_ones_window_acc.sv
// Scoreboard bench for ones_window_acc: a window model queues expected
// results at drive time; they are popped and compared on each out_vld.
module tb_ones_window_acc;

    logic       sys_clk;
    logic       in_rst_n;
    logic       in_vld;
    logic [5:0] in_cnt;
    logic       in_clr;
    logic       out_vld;
    logic [9:0] out_sum;
    logic [5:0] out_max;
    logic [5:0] out_min;
    logic       out_alarm_hi;
    logic       out_alarm_lo;
    logic       out_err;

    ones_window_acc dut (
        .sys_clk     (sys_clk),
        .in_rst_n    (in_rst_n),
        .in_vld      (in_vld),
        .in_cnt      (in_cnt),
        .in_clr      (in_clr),
        .out_vld     (out_vld),
        .out_sum     (out_sum),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_alarm_hi(out_alarm_hi),
        .out_alarm_lo(out_alarm_lo),
        .out_err     (out_err)
    );

    typedef struct {
        int sum;
        int mx;
        int mn;
        int hi;
        int lo;
        int due;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   m_cnt, m_sum, m_max, m_min;
    int   n_vld  = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_sum = 0;
        m_max = 0;
        m_min = 63;
    endtask

    // Drive one cycle of inputs and advance the model for the coming edge.
    task automatic drive(input logic v, input logic c, input int val);
        int s;
        exp_t e;
        @(posedge sys_clk);
        #1;
        in_vld = v;
        in_clr = c;
        in_cnt = val[5:0];
        if (c) begin
            model_reset();
        end else if (v) begin
            s = (val > 32) ? 32 : val;
            m_sum += s;
            if (s > m_max) m_max = s;
            if (s < m_min) m_min = s;
            m_cnt++;
            if (m_cnt == 16) begin
                e.sum = m_sum;
                e.mx  = m_max;
                e.mn  = m_min;
                e.hi  = (m_sum > 400) ? 1 : 0;
                e.lo  = (m_sum < 64) ? 1 : 0;
                e.due = cyc + 2;
                q.push_back(e);
                model_reset();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    task automatic send_n(input int n, input int val);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, val);
    endtask

    task automatic expect_drained(input string tag);
        idle(4);
        chk(tag, q.size(), 0);
        q.delete();
    endtask

    always @(negedge sys_clk) begin
        if (out_vld) begin
            exp_t e;
            n_vld++;
            if (q.size() == 0) begin
                chk("unexpected_vld", 1, 0);
            end else begin
                e = q.pop_front();
                chk("vld_cycle", cyc, e.due);
                chk("sum", int'(out_sum), e.sum);
                chk("max", int'(out_max), e.mx);
                chk("min", int'(out_min), e.mn);
                chk("alarm_hi", int'(out_alarm_hi), e.hi);
                chk("alarm_lo", int'(out_alarm_lo), e.lo);
            end
        end
    end

    initial begin
        #40000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_vld"}, int'(out_vld), 0);
        chk({tag, "_sum"}, int'(out_sum), 0);
        chk({tag, "_max"}, int'(out_max), 0);
        chk({tag, "_min"}, int'(out_min), 0);
        chk({tag, "_hi"}, int'(out_alarm_hi), 0);
        chk({tag, "_lo"}, int'(out_alarm_lo), 0);
        chk({tag, "_err"}, int'(out_err), 0);
    endtask

    initial begin
        int nv;
        in_rst_n = 1'b0;
        in_vld   = 1'b0;
        in_clr   = 1'b0;
        in_cnt   = '0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk_zero_outs("por");
        in_rst_n = 1'b1;

        // Ramp 1..16 back to back.
        nv = n_vld;
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, i);
        expect_drained("ramp_pending");
        chk("ramp_pulses", n_vld - nv, 1);

        // Reset mid-window, then a fresh window of 10s.
        send_n(8, 3);
        @(posedge sys_clk);
        #1;
        in_vld   = 1'b0;
        in_rst_n = 1'b0;
        model_reset();
        #2;
        chk_zero_outs("rst");
        repeat (2) @(posedge sys_clk);
        #1;
        in_rst_n = 1'b1;
        nv = n_vld;
        send_n(16, 10);
        expect_drained("rst_pending");
        chk("rst_pulses", n_vld - nv, 1);

        // Saturated window followed without a gap by a sparse low window.
        nv = n_vld;
        send_n(16, 32);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 2);
            idle(1);
        end
        expect_drained("sat_pending");
        chk("sat_pulses", n_vld - nv, 2);

        // Clear discards a partial window and the coinciding sample.
        nv = n_vld;
        send_n(10, 7);
        drive(1'b1, 1'b1, 9);
        send_n(16, 5);
        expect_drained("clr_pending");
        chk("clr_pulses", n_vld - nv, 1);
        chk("clr_hold_sum", int'(out_sum), 80);

        // Illegal sample saturates and sets the sticky error.
        send_n(4, 1);
        drive(1'b1, 1'b0, 40);
        send_n(11, 1);
        expect_drained("ill_pending");
        chk("ill_err", int'(out_err), 1);

        // Gapped window of 4s; error must persist across it.
        nv = n_vld;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 4);
            idle($urandom_range(0, 3));
        end
        expect_drained("gap_pending");
        chk("gap_pulses", n_vld - nv, 1);
        chk("gap_err_sticky", int'(out_err), 1);

        drive(1'b0, 1'b1, 0);
        idle(2);
        chk("clr_err", int'(out_err), 0);
        chk("clr_keep_sum", int'(out_sum), 64);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
